// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: instruction-memory req/ack port, redirect input and the
// instruction handshake towards the decoder. master = fetch unit, slave = environment.
interface fetch_unit_if;
    logic [31:0] imem_addr_o;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic        imem_err_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        e_fetch_fault_o;
    logic        e_misaligned_o;

    modport master (
        output imem_addr_o, imem_req_o, instruction_o, pc_o, valid_o,
               e_fetch_fault_o, e_misaligned_o,
        input  imem_ack_i, imem_err_i, imem_data_i, redirect_i, redirect_pc_i, ready_i
    );

    modport slave (
        input  imem_addr_o, imem_req_o, instruction_o, pc_o, valid_o,
               e_fetch_fault_o, e_misaligned_o,
        output imem_ack_i, imem_err_i, imem_data_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads into a small PC-tagged FIFO.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirects into a marker entry + halt.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_unit_if.master bus
);
    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StFlush, StHalt} state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        mis_pend_q;

    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            fault_mem [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, wr_idx;
    logic [CntW-1:0] count_q;

    logic        valid, pop, resp, outstanding, space_idle, space_after;
    logic [31:0] redir_pc, pc_inc;
    logic        redir_mis;
    logic        buf_clear, push, push_fault, push_mis;
    logic [31:0] push_pc, push_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc  = bus.redirect_pc_i;
    assign redir_mis = |bus.redirect_pc_i[1:0];
`else
    assign redir_pc  = {bus.redirect_pc_i[31:2], 2'b00};
    assign redir_mis = 1'b0;
`endif

    assign valid       = (count_q != '0);
    assign pop         = valid & bus.ready_i;
    assign resp        = bus.imem_ack_i | bus.imem_err_i;
    assign outstanding = (state_q == StReq) || (state_q == StFlush);
    assign space_idle  = (count_q - CntW'(pop)) < DepthCnt;
    assign space_after = (count_q + CntW'(1) - CntW'(pop)) < DepthCnt;
    assign pc_inc      = fetch_pc_q + 32'd4;

    always_comb begin
        buf_clear  = 1'b0;
        push       = 1'b0;
        push_fault = 1'b0;
        push_mis   = 1'b0;
        push_pc    = fetch_pc_q;
        push_instr = '0;
        if (bus.redirect_i) begin
            buf_clear = 1'b1;
            // Marker goes in at once unless a response must still be drained.
            if (redir_mis && !(outstanding && !resp)) begin
                push     = 1'b1;
                push_mis = 1'b1;
                push_pc  = redir_pc;
            end
        end else if (state_q == StReq && resp) begin
            push       = 1'b1;
            push_fault = bus.imem_err_i;
            push_instr = bus.imem_err_i ? '0 : bus.imem_data_i;
        end else if (state_q == StFlush && resp && mis_pend_q) begin
            push     = 1'b1;
            push_mis = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            mis_pend_q <= 1'b0;
        end else if (bus.redirect_i) begin
            fetch_pc_q <= redir_pc;
            mis_pend_q <= 1'b0;
            if (outstanding && !resp) begin
                state_q    <= StFlush;
                mis_pend_q <= redir_mis;
            end else if (redir_mis) begin
                state_q <= StHalt;
                req_q   <= 1'b0;
            end else begin
                state_q <= StReq;
                req_q   <= 1'b1;
                addr_q  <= redir_pc;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (space_idle) begin
                        state_q <= StReq;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                StReq: begin
                    if (bus.imem_err_i) begin
                        state_q <= StHalt;
                        req_q   <= 1'b0;
                    end else if (bus.imem_ack_i) begin
                        fetch_pc_q <= pc_inc;
                        if (space_after) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                end
                StFlush: begin
                    if (resp) begin
                        mis_pend_q <= 1'b0;
                        if (mis_pend_q) begin
                            state_q <= StHalt;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= StReq;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                end
                StHalt: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (buf_clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push ? PtrW'(1) : '0;
            count_q  <= push ? CntW'(1) : '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign wr_idx = buf_clear ? '0 : wr_ptr_q;

    // Storage is unreset; the head fields are masked by valid instead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_idx]    <= push_pc;
            instr_mem[wr_idx] <= push_instr;
            fault_mem[wr_idx] <= push_fault;
        end
    end

    assign bus.imem_addr_o     = addr_q;
    assign bus.imem_req_o      = req_q;
    assign bus.valid_o         = valid;
    assign bus.instruction_o   = valid ? instr_mem[rd_ptr_q] : '0;
    assign bus.pc_o            = valid ? pc_mem[rd_ptr_q] : '0;
    assign bus.e_fetch_fault_o = valid & fault_mem[rd_ptr_q];

`ifdef FETCH_MISALIGN_CHECK_EN
    logic mis_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) mis_mem[wr_idx] <= push_mis;
    end

    assign bus.e_misaligned_o = valid & mis_mem[rd_ptr_q];
`else
    logic unused_mis;
    assign unused_mis         = push_mis ^ (^bus.redirect_pc_i[1:0]);
    assign bus.e_misaligned_o = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset-mid-request sequence and a randomized
// run checked against a queue-based model of the fetch stream.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned DEPTH    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.master)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ack, err, ready, redir;
        logic [31:0] rpc, data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
        logic        e_fault, e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic err, input logic ready, input logic redir,
                         input logic [31:0] rpc, input logic [31:0] data);
        bus.imem_ack_i    = ack;
        bus.imem_err_i    = err;
        bus.ready_i       = ready;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = rpc;
        bus.imem_data_i   = data;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic ack, input logic err, input logic ready,
                                input logic redir, input logic [31:0] rpc,
                                input logic [31:0] data, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_fault, input logic e_mis);
        vec_t v;
        v.ack = ack; v.err = err; v.ready = ready; v.redir = redir;
        v.rpc = rpc; v.data = data;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_fault = e_fault; v.e_mis = e_mis;
        return v;
    endfunction

    vec_t vecs [21];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t        q[$];
        ent_t        e;
        logic [31:0] exp_pc, rnd, rpc, data;
        logic        r_req, ack, err, ready, redir, pop, rsp;
        bit          flushing, halted;
        int          accepted;

        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Inputs apply during the row's cycle; expectations are the outputs at its start.
        //             ack err rdy rd  rpc           data           req addr          vld instr         pc            flt mis
        vecs[0]  = mk(1, 0, 1, 0, 32'h0,         32'h1111_0000, 0, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0);
        vecs[1]  = mk(1, 0, 1, 0, 32'h0,         32'h1111_0001, 1, 32'h8000_0000, 0, 32'h0,         32'h0,         0, 0);
        vecs[2]  = mk(1, 0, 1, 0, 32'h0,         32'h1111_0002, 1, 32'h8000_0004, 1, 32'h1111_0001, 32'h8000_0000, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 32'h0,         32'h1111_0003, 1, 32'h8000_0008, 1, 32'h1111_0002, 32'h8000_0004, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 32'h0,         32'h1111_0004, 0, 32'h8000_0008, 1, 32'h1111_0002, 32'h8000_0004, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 32'h0,         32'h1111_0005, 0, 32'h8000_0008, 1, 32'h1111_0002, 32'h8000_0004, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,         32'h1111_0006, 1, 32'h8000_000C, 1, 32'h1111_0003, 32'h8000_0008, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 32'h0,         32'h0,         0, 32'h8000_000C, 1, 32'h1111_0003, 32'h8000_0008, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h8000_0010, 1, 32'h1111_0006, 32'h8000_000C, 0, 0);
        vecs[9]  = mk(0, 0, 1, 1, 32'h0000_0100, 32'h0,         1, 32'h8000_0010, 0, 32'h0,         32'h0,         0, 0);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h8000_0010, 0, 32'h0,         32'h0,         0, 0);
        vecs[11] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h8000_0010, 0, 32'h0,         32'h0,         0, 0);
        vecs[12] = mk(1, 0, 1, 0, 32'h0,         32'hDEAD_BEEF, 1, 32'h8000_0010, 0, 32'h0,         32'h0,         0, 0);
        vecs[13] = mk(1, 0, 0, 0, 32'h0,         32'h2222_0000, 1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0);
        vecs[14] = mk(1, 0, 0, 1, 32'h8000_0008, 32'h3333_3333, 1, 32'h0000_0104, 1, 32'h2222_0000, 32'h0000_0100, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,         32'h4444_4444, 1, 32'h8000_0008, 0, 32'h0,         32'h0,         0, 0);
        vecs[16] = mk(0, 0, 0, 0, 32'h0,         32'h0,         0, 32'h8000_0008, 1, 32'h0,         32'h8000_0008, 1, 0);
        vecs[17] = mk(1, 0, 0, 0, 32'h0,         32'h5555_5555, 0, 32'h8000_0008, 1, 32'h0,         32'h8000_0008, 1, 0);
        vecs[18] = mk(0, 0, 0, 1, 32'h0000_0102, 32'h0,         0, 32'h8000_0008, 1, 32'h0,         32'h8000_0008, 1, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs[19] = mk(0, 0, 1, 0, 32'h0,         32'h0,         0, 32'h8000_0008, 1, 32'h0,         32'h0000_0102, 0, 1);
        vecs[20] = mk(0, 0, 1, 0, 32'h0,         32'h0,         0, 32'h8000_0008, 0, 32'h0,         32'h0,         0, 0);
`else
        vecs[19] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0);
        vecs[20] = mk(0, 0, 1, 0, 32'h0,         32'h0,         1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0);
`endif

        apply_reset();
        for (int i = 0; i < 21; i++) begin
            chk($sformatf("vec%0d req", i),   bus.imem_req_o,      vecs[i].e_req);
            chk($sformatf("vec%0d addr", i),  bus.imem_addr_o,     vecs[i].e_addr);
            chk($sformatf("vec%0d valid", i), bus.valid_o,         vecs[i].e_valid);
            chk($sformatf("vec%0d instr", i), bus.instruction_o,   vecs[i].e_instr);
            chk($sformatf("vec%0d pc", i),    bus.pc_o,            vecs[i].e_pc);
            chk($sformatf("vec%0d fault", i), bus.e_fetch_fault_o, vecs[i].e_fault);
            chk($sformatf("vec%0d mis", i),   bus.e_misaligned_o,  vecs[i].e_mis);
            drive(vecs[i].ack, vecs[i].err, vecs[i].ready, vecs[i].redir, vecs[i].rpc,
                  vecs[i].data);
            @(negedge clk);
        end

        // Reset with a request outstanding and a buffered entry; a late ack must be ignored.
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 32'hAAAA_0000);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("rstmid pre req", bus.imem_req_o, 1'b1);
        chk("rstmid pre valid", bus.valid_o, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid req", bus.imem_req_o, 1'b0);
        chk("rstmid valid", bus.valid_o, 1'b0);
        chk("rstmid addr", bus.imem_addr_o, RESET_PC);
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 32'hBBBB_BBBB);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid late ack valid", bus.valid_o, 1'b0);
        chk("rstmid restart req", bus.imem_req_o, 1'b1);
        chk("rstmid restart addr", bus.imem_addr_o, RESET_PC);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h1234_5678);
        @(negedge clk);
        chk("rstmid first pc", bus.pc_o, RESET_PC);
        chk("rstmid first instr", bus.instruction_o, 32'h1234_5678);

        // Randomized run against a queue model of the expected instruction stream.
        apply_reset();
        exp_pc   = RESET_PC;
        flushing = 1'b0;
        halted   = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd valid", bus.valid_o, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd pc", bus.pc_o, q[0].pc);
                chk("rnd instr", bus.instruction_o, q[0].instr);
                chk("rnd fault", bus.e_fetch_fault_o, q[0].fault);
            end
            chk("rnd mis", bus.e_misaligned_o, 1'b0);
            r_req = bus.imem_req_o;
            if (halted) chk("rnd halt noreq", r_req, 1'b0);
            else if (r_req && !flushing) chk("rnd addr", bus.imem_addr_o, exp_pc);

            ready = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            ack   = r_req && ($urandom_range(0, 1) == 1);
            err   = r_req && !ack && ($urandom_range(0, 63) == 0);
            rnd   = $urandom();
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : {rnd[31:2], 2'b00};
            data  = $urandom();
            drive(ack, err, ready, redir, rpc, data);

            pop = (q.size() != 0) && ready;
            rsp = r_req && (ack || err);
            if (redir) begin
                q.delete();
                exp_pc   = rpc;
                halted   = 1'b0;
                flushing = r_req && !rsp;
            end else begin
                if (pop) void'(q.pop_front());
                if (rsp) begin
                    if (flushing) begin
                        flushing = 1'b0;
                    end else if (err) begin
                        e.pc = exp_pc; e.instr = 32'h0; e.fault = 1'b1;
                        q.push_back(e);
                        halted = 1'b1;
                    end else begin
                        e.pc = exp_pc; e.instr = data; e.fault = 1'b0;
                        q.push_back(e);
                        exp_pc = exp_pc + 32'd4;
                        accepted++;
                    end
                end
                chk("rnd occupancy", q.size() <= DEPTH, 1'b1);
            end
            @(negedge clk);
        end
        chk("rnd progress", accepted > 300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
